// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial add controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MAX = 16;

  // Bit counter width: wide enough to hold WIDTH itself.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder; one instance is time-shared across all operand bits.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller, LSB first, one bit per clk through a shared fa_cell.
// Optional SERIAL_ADD_SUB_EN adds a 'sub' input for two's-complement a - b.
//
// state | meaning
// IDLE  | waiting for start; sum holds last result
// RUN   | one operand bit per cycle through the shared cell
// DONE  | one-cycle done pulse, then back to IDLE
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_next;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             s;
  logic             co;
  logic             sub_sel;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  fa_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (s),
    .cout (co)
  );

  // New result bit enters at the MSB; the concat keeps WIDTH=1 legal.
  assign r_next = WIDTH'({s, r_sr} >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= sub_sel ? ~b : b;
            carry <= sub_sel;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          r_sr  <= r_next;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= co;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            sum   <= {co, r_next};
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=4 and WIDTH=2 instances).
// Build with +define+SERIAL_ADD_SUB_EN to exercise the subtract option.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       sub_r;
  logic [4:0] sum;
  logic       busy;
  logic       done;

  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic [2:0] sum2;
  logic       busy2;
  logic       done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub_r),
`endif
    .start (start),
    .a     (a),
    .b     (b),
    .sum   (sum),
    .busy  (busy),
    .done  (done)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst   (rst),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (1'b0),
`endif
    .start (start2),
    .a     (a2),
    .b     (b2),
    .sum   (sum2),
    .busy  (busy2),
    .done  (done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic int model(input int w, input int ia, input int ib, input bit isub);
    if (isub) return (ia + (1 << w) - ib) % (1 << (w + 1));
    return ia + ib;
  endfunction

  // Start one WIDTH=4 op, scramble inputs while it runs, wait (bounded) for done.
  task automatic do_op4(input logic [3:0] ia, input logic [3:0] ib, input logic isub,
                        output logic [4:0] osum, output int olat, output int obusy,
                        output bit omoved);
    logic [4:0] prev;
    prev  = sum;
    a     = ia;
    b     = ib;
    sub_r = isub;
    start = 1'b1;
    tick();
    start  = 1'b0;
    olat   = 1;
    obusy  = 0;
    omoved = 1'b0;
    while (done !== 1'b1 && olat < 40) begin
      if (busy === 1'b1) obusy++;
      if (sum !== prev) omoved = 1'b1;
      a     = 4'($urandom);
      b     = 4'($urandom);
      sub_r = 1'($urandom);
      start = 1'($urandom);
      tick();
      olat++;
    end
    start = 1'b0;
    osum  = sum;
    if (olat >= 40) olat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; sub_r = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0;
    tick();
    tick();
    checks++;
    if (sum !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: sum=%0d busy=%b done=%b, want 0/0/0", sum, busy, done);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [4:0] s; int lat; int bc; bit moved;
    do_op4(4'd9, 4'd8, 1'b0, s, lat, bc, moved);
    checks++;
    if (s !== 5'd17) begin errors++; $display("FAIL basic_9_8: sum=%0d want 17", s); end
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL basic_latency: done at cycle %0d want 5", lat); end
    checks++;
    if (bc !== 4) begin errors++; $display("FAIL basic_busy: busy cycles=%0d want 4", bc); end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_pulse_width: done=%b busy=%b want 0/0", done, busy);
    end
    do_op4(4'd15, 4'd15, 1'b0, s, lat, bc, moved);
    checks++;
    if (s !== 5'd30) begin errors++; $display("FAIL basic_15_15: sum=%0d want 30", s); end
    tick();
    do_op4(4'd0, 4'd0, 1'b0, s, lat, bc, moved);
    checks++;
    if (s !== 5'd0 || moved) begin
      errors++; $display("FAIL basic_0_0_hold: sum=%0d moved_early=%b want 0/0", s, moved);
    end
    tick();
  endtask

  task automatic test_random();
    logic [4:0] s; int lat; int bc; bit moved; int ra; int rb; int exp;
    for (int i = 0; i < 20; i++) begin
      ra = int'($urandom_range(0, 15));
      rb = int'($urandom_range(0, 15));
      exp = model(4, ra, rb, 1'b0);
      do_op4(4'(ra), 4'(rb), 1'b0, s, lat, bc, moved);
      checks++;
      if (s !== 5'(exp) || lat !== 5 || moved) begin
        errors++;
        $display("FAIL random_add[%0d]: %0d+%0d sum=%0d lat=%0d moved=%b want %0d/5/0",
                 i, ra, rb, s, lat, moved, exp);
      end
      tick();
    end
  endtask

  task automatic test_sweep_w2();
    int lat; int ndone; int exp;
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        exp = model(2, ia, ib, 1'b0);
        a2 = 2'(ia); b2 = 2'(ib); start2 = 1'b1;
        tick();
        start2 = 1'b0;
        ndone = 0; lat = -1;
        for (int c = 1; c <= 8; c++) begin
          if (done2 === 1'b1) begin
            ndone++;
            if (lat < 0) lat = c;
            checks++;
            if (sum2 !== 3'(exp)) begin
              errors++; $display("FAIL w2_sum: %0d+%0d sum=%0d want %0d", ia, ib, sum2, exp);
            end
          end
          a2 = 2'($urandom); b2 = 2'($urandom);
          tick();
        end
        checks++;
        if (ndone !== 1 || lat !== 3) begin
          errors++; $display("FAIL w2_done: %0d+%0d dones=%0d at=%0d want 1/3", ia, ib, ndone, lat);
        end
      end
    end
  endtask

  task automatic test_start_held();
    int last; int ndone;
    a = 4'd3; b = 4'd4; sub_r = 1'b0; start = 1'b1;
    last = -1; ndone = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done === 1'b1) begin
        checks++;
        if (sum !== 5'd7) begin errors++; $display("FAIL held_sum: sum=%0d want 7", sum); end
        if (last >= 0) begin
          checks++;
          if (c - last !== 6) begin
            errors++; $display("FAIL held_period: gap=%0d want 6", c - last);
          end
        end
        last = c;
        ndone++;
      end
      if (busy === 1'b1) begin a = 4'($urandom); b = 4'($urandom); end
      else begin a = 4'd3; b = 4'd4; end
    end
    start = 1'b0;
    checks++;
    if (ndone < 6) begin errors++; $display("FAIL held_count: dones=%0d want >=6", ndone); end
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_run();
    logic [4:0] s; int lat; int bc; bit moved; int nd;
    do_op4(4'd9, 4'd8, 1'b0, s, lat, bc, moved);
    tick();
    a = 4'd7; b = 4'd6; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (sum !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_state: sum=%0d busy=%b done=%b want 0/0/0", sum, busy, done);
    end
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      if (done === 1'b1 || busy === 1'b1) nd++;
      tick();
    end
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL abort_quiet: active cycles=%0d want 0", nd); end
    do_op4(4'd1, 4'd1, 1'b0, s, lat, bc, moved);
    checks++;
    if (s !== 5'd2) begin errors++; $display("FAIL after_abort: sum=%0d want 2", s); end
    tick();
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    logic [4:0] s; int lat; int bc; bit moved; int ra; int rb; bit rs; int exp;
    do_op4(4'd5, 4'd3, 1'b1, s, lat, bc, moved);
    checks++;
    if (s !== 5'b1_0010) begin errors++; $display("FAIL sub_5_3: sum=%b want 10010", s); end
    tick();
    do_op4(4'd3, 4'd5, 1'b1, s, lat, bc, moved);
    checks++;
    if (s !== 5'b0_1110) begin errors++; $display("FAIL sub_3_5: sum=%b want 01110", s); end
    tick();
    do_op4(4'd5, 4'd3, 1'b0, s, lat, bc, moved);
    checks++;
    if (s !== 5'd8) begin errors++; $display("FAIL sub0_5_3: sum=%0d want 8", s); end
    tick();
    for (int i = 0; i < 12; i++) begin
      ra = int'($urandom_range(0, 15));
      rb = int'($urandom_range(0, 15));
      rs = 1'($urandom);
      exp = model(4, ra, rb, rs);
      do_op4(4'(ra), 4'(rb), rs, s, lat, bc, moved);
      checks++;
      if (s !== 5'(exp)) begin
        errors++; $display("FAIL sub_random[%0d]: a=%0d b=%0d sub=%b sum=%0d want %0d",
                           i, ra, rb, rs, s, exp);
      end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_sweep_w2();
    test_start_held();
    test_reset_mid_run();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
